// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the multiplier / BCD converter / display chain.
package product_bcd_converter_pkg;
   localparam int unsigned DEF_WIDTH  = 16;
   localparam int unsigned DEF_DIGITS = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } conv_state_e;
endpackage

// File: rtl/product_bcd_converter_bcd_add3_digit.sv
// Double-dabble digit correction: bias a BCD digit by 3 when it is 5 or more.
module bcd_add3_digit (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);
   assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 iteration per clock,
// producing packed BCD digits, a latched sign and a leading-zero blank mask.
module product_bcd_converter
   import product_bcd_converter_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned DIGITS = DEF_DIGITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    bin_in,
   input  logic                neg_in,
   output logic                busy,
   output logic                done,
   output logic [DIGITS*4-1:0] bcd_out,
   output logic                neg_out,
   output logic [DIGITS-1:0]   blank
);
   localparam int unsigned BCD_W = DIGITS * 4;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   conv_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic [BCD_W-1:0]  scr_q, scr_d;
   logic              sign_q, sign_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic              neg_q, neg_d;
   logic [DIGITS-1:0] blank_q, blank_d;

   logic [BCD_W-1:0]  scr_corr;
   logic [BCD_W-1:0]  scr_shift;
   logic [DIGITS-1:0] blank_calc;
   logic              upper_zero;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_digit u_add3 (
         .digit_i (scr_q[g*4 +: 4]),
         .digit_o (scr_corr[g*4 +: 4])
      );
   end

   assign scr_shift = {scr_corr[BCD_W-2:0], bin_q[WIDTH-1]};

   // A digit blanks only while every digit above it is also zero; units never blank.
   always_comb begin
      blank_calc = '0;
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         upper_zero    = upper_zero & (scr_shift[i*4 +: 4] == 4'd0);
         blank_calc[i] = upper_zero;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      scr_d   = scr_q;
      sign_d  = sign_q;
      bcd_d   = bcd_q;
      neg_d   = neg_q;
      blank_d = blank_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CONVERT;
               bin_d   = bin_in;
               sign_d  = neg_in;
               scr_d   = '0;
               cnt_d   = '0;
            end
         end
         CONVERT: begin
            scr_d = scr_shift;
            bin_d = {bin_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               bcd_d   = scr_shift;
               neg_d   = sign_q;
               blank_d = blank_calc;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         scr_q   <= '0;
         sign_q  <= 1'b0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         blank_q <= BLANK_RST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         sign_q  <= sign_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         blank_q <= blank_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign bcd_out = bcd_q;
   assign neg_out = neg_q;
   assign blank   = blank_q;
endmodule
